// File: rtl/edge_pkg.sv
// Shared constants and FSM encoding for the edge-detector line-delay path.
package edge_pkg;

  localparam int LINE_DEPTH  = 76;
  localparam int PIXEL_W     = 32;
  localparam int LINE_ADDR_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/line_delay_ctrl_ring_ptr.sv
// Circular pointer that counts 0..DEPTH-1 and pulses wrap_o on the DEPTH-1 -> 0 step.
module ring_ptr #(
  parameter int DEPTH  = 76,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              wrap_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Clear wins over increment, so no wrap is reported on a cleared cycle.
  assign wrap_o = inc_i && !clr_i && (ptr_q == LAST);
  assign ptr_o  = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/line_delay_ctrl.sv
// One-line delay controller: read-then-overwrite at a circular pointer, emitting (cur, prev) pairs.
module line_delay_ctrl
  import edge_pkg::*;
#(
  parameter int DEPTH  = LINE_DEPTH,
  parameter int WIDTH  = PIXEL_W,
  parameter int ADDR_W = LINE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_cur,
  output logic [WIDTH-1:0]  out_prev,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output ld_state_t         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE and out_valid only in HOLD, so a new
  // sample is never taken while a pair is still waiting downstream.

  ld_state_t         state_q, state_d;
  logic [WIDTH-1:0]  sample_q, cur_q, prev_q;
  logic              filled_q;
  logic [ADDR_W-1:0] ptr;
  logic              wrap;
  logic              accept;
  logic              in_write;
  logic              load_out;

  assign accept   = (state_q == ST_IDLE) && in_valid && !flush;
  assign in_write = (state_q == ST_WRITE);
  assign load_out = in_write && filled_q && !flush;

  ring_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush),
    .inc_i  (in_write),
    .ptr_o  (ptr),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = filled_q ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // filled is taken from its value before this write, so the wrapping
  // sample itself still produces no output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      cur_q    <= '0;
      prev_q   <= '0;
      filled_q <= 1'b0;
    end else begin
      if (accept) sample_q <= in_data;
      if (flush) begin
        filled_q <= 1'b0;
      end else if (wrap) begin
        filled_q <= 1'b1;
      end
      if (load_out) begin
        cur_q  <= sample_q;
        prev_q <= mem_rd_data;
      end
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_HOLD);
  assign out_cur      = cur_q;
  assign out_prev     = prev_q;
  assign mem_write_en = in_write;
  assign mem_addr     = ptr;
  assign mem_wr_data  = in_write ? sample_q : '0;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Directed bench for line_delay_ctrl with a registered-read line memory model.
module tb_line_delay_ctrl;
  import edge_pkg::*;

  localparam int D = 76;
  localparam int W = 32;
  localparam int A = 7;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_cur;
  logic [W-1:0] out_prev;
  logic         mem_write_en;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wr_data;
  logic [W-1:0] mem_rd_data;
  ld_state_t    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  logic [W-1:0] mem [0:D-1];
  logic [W-1:0] exp_q[$];
  logic [A-1:0] exp_ptr;

  line_delay_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cur      (out_cur),
    .out_prev     (out_prev),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line memory model: read data registered, one cycle after the address.
  always @(posedge clk) begin
    if (mem_write_en) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(mem_addr) < D) mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= (int'(mem_addr) < D) ? mem[mem_addr] : 'x;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_cur"},  out_cur, '0);
    check({tag, "_out_prev"}, out_prev, '0);
    check({tag, "_mem_we"},   32'(mem_write_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wr_data, '0);
  endtask

  // Drivers: one accepted sample, checked through READ, WRITE and any HOLD.
  task automatic send(input logic [W-1:0] d, input int bp, input bit do_flush);
    int           wr0;
    bit           eout;
    logic [W-1:0] eprev;
    logic [A-1:0] eaddr;
    eaddr = exp_ptr;
    eout  = (exp_q.size() == D);
    eprev = eout ? exp_q.pop_front() : '0;
    exp_q.push_back(d);
    exp_ptr = (exp_ptr == A'(D - 1)) ? '0 : exp_ptr + 1'b1;

    for (int i = 0; i < 8 && !in_ready; i++) step();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    wr0       = wr_cnt;
    out_ready = (bp == 0) && !do_flush;
    in_valid  = 1'b1;
    in_data   = d;
    step();
    in_valid  = 1'b0;
    in_data   = '0;
    check("read_state", 32'(dbg_state), 32'(ST_READ));
    check("read_we", 32'(mem_write_en), 32'd0);
    check("read_addr", 32'(mem_addr), 32'(eaddr));
    check("read_in_ready", 32'(in_ready), 32'd0);
    step();
    check("write_we", 32'(mem_write_en), 32'd1);
    check("write_addr", 32'(mem_addr), 32'(eaddr));
    check("write_data", mem_wr_data, d);
    step();
    check("write_count", 32'(wr_cnt), 32'(wr0 + 1));
    if (eout) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_cur", out_cur, d);
      check("hold_prev", out_prev, eprev);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < bp; i++) begin
        step();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_cur", out_cur, d);
        check("bp_prev", out_prev, eprev);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_we", 32'(mem_write_en), 32'd0);
        check("bp_write_count", 32'(wr_cnt), 32'(wr0 + 1));
      end
      if (do_flush) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        exp_ptr = '0;
      end else begin
        out_ready = 1'b1;
        step();
        check("release_valid", 32'(out_valid), 32'd0);
      end
    end else begin
      check("fill_no_valid", 32'(out_valid), 32'd0);
      check("fill_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < D; i++) mem[i] = '0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    exp_ptr   = '0;

    // Reset state
    step();
    step();
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    step();
    check_reset_outputs("rst_release");

    // Fill, first output, wrap, backpressure on sample 120
    for (int n = 1; n <= 76; n++) send(W'(n), 0, 1'b0);
    send(W'(77), 0, 1'b0);
    check("first_prev", out_prev, 32'd1);
    for (int n = 78; n <= 153; n++) send(W'(n), (n == 120) ? 10 : 0, 1'b0);
    check("wrap_last_prev", out_prev, 32'd77);

    // Async reset while in READ abandons the write
    in_valid = 1'b1;
    in_data  = 32'd154;
    step();
    in_valid = 1'b0;
    check("pre_reset_state", 32'(dbg_state), 32'(ST_READ));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    wr0 = wr_cnt;
    step();
    step();
    check("async_rst_no_write", 32'(wr_cnt), 32'(wr0));
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    exp_ptr = '0;

    // Refill after reset, then flush while holding sample 100
    for (int n = 1; n <= 99; n++) send(W'(1000 + n), 0, 1'b0);
    send(32'd1100, 2, 1'b1);

    // Flush and in_valid together in IDLE: sample not taken
    wr0      = wr_cnt;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    check("flush_wins_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    check("flush_wins_no_write", 32'(wr_cnt), 32'(wr0));

    // Post-flush fill restarts at address 0
    for (int n = 1; n <= 77; n++) send(W'(2000 + n), 0, 1'b0);
    check("post_flush_prev", out_prev, 32'd2001);
    check("post_flush_cur", out_cur, 32'd2077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
